// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem masters, the arbiter and the data memory.
// The arbiter takes the slave view; masters and memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_stall;

    logic              p1_req;
    logic              p1_lock;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rdata, p0_stall,
        input  p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rdata, p0_stall,
        output p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: processor (port 0) vs. loader/debug (port 1) with
// bounded port-1 locking. Grants are combinational from registered state.
module dmem_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic [15:0]   conflict_cnt
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
    localparam logic [CW-1:0] LOCK_ONE = CW'(1);

    typedef enum logic [1:0] {ARB, LOCKED, RELEASE} state_t;

    state_t        state, state_nxt;
    logic          prio, prio_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          g0, g1;
    logic          conflict, lock_hold;

    assign conflict  = bus.p0_req & bus.p1_req;
    assign lock_hold = bus.p1_req & bus.p1_lock;

    // Returns {g1, g0}; on conflict the port named by pr wins.
    function automatic logic [1:0] pick(input logic r0, input logic r1, input logic pr);
        if (r0 && r1)
            return pr ? 2'b10 : 2'b01;
        return {r1, r0};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB;
            prio         <= 1'b0;
            lock_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (conflict && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // After a conflict prio points at the loser, i.e. at port 1 iff port 0 won.
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        lock_cnt_nxt = lock_cnt;
        case (state)
            LOCKED: begin
                if (lock_hold && lock_cnt < LOCK_MAX) begin
                    lock_cnt_nxt = lock_cnt + LOCK_ONE;
                end else if (!lock_hold) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    prio_nxt     = conflict ? g0 : 1'b0;
                end else begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    prio_nxt     = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
                prio_nxt     = 1'b1;
            end
            default: begin
                if (conflict)
                    prio_nxt = g0;
                if (g1 && bus.p1_lock) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = LOCK_ONE;
                end
            end
        endcase
    end

    // An exhausted lock gives port 0 the same absolute priority as RELEASE.
    always_comb begin
        {g1, g0} = 2'b00;
        case (state)
            LOCKED: begin
                if (lock_hold && lock_cnt < LOCK_MAX)
                    g1 = 1'b1;
                else if (!lock_hold)
                    {g1, g0} = pick(bus.p0_req, bus.p1_req, 1'b0);
                else
                    {g1, g0} = {bus.p1_req & ~bus.p0_req, bus.p0_req};
            end
            RELEASE: {g1, g0} = {bus.p1_req & ~bus.p0_req, bus.p0_req};
            default: {g1, g0} = pick(bus.p0_req, bus.p1_req, prio);
        endcase
        if (!rst)
            {g1, g0} = 2'b00;

        bus.p0_gnt    = g0;
        bus.p1_gnt    = g1;
        bus.p0_stall  = bus.p0_req & ~g0;
        bus.p0_rdata  = bus.mem_rdata;
        bus.p1_rdata  = bus.mem_rdata;
        bus.mem_we    = (g0 & bus.p0_we) | (g1 & bus.p1_we);
        bus.mem_addr  = g1 ? bus.p1_addr  : bus.p0_addr;
        bus.mem_wdata = g1 ? bus.p1_wdata : bus.p0_wdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver queues expected per-cycle
// results and a negedge monitor pops and compares them.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rstReq = 1'b0;
    logic [15:0] conflictCnt;
    logic [31:0] mem [0:255];
    logic [15:0] expCnt = 16'd0;
    int          testsRun = 0;
    int          testsFailed = 0;

    typedef struct {
        string       tag;
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [15:0] cnt;
        bit          chkData;
        logic [31:0] rdata;
    } exp_t;

    exp_t expQ[$];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.MAX_LOCK(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .conflict_cnt (conflictCnt)
    );

    always #5 clk = ~clk;

    // Combinational-read memory model with writes committing on the rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk)
        if (bus.mem_we)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and queues the
    // expected response; e0/e1 are the hand-derived grants.
    task automatic applyStimulus(input string tag,
                                 input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input bit r1, input bit l1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                                 input bit e0, input bit e1, input bit chk, input logic [31:0] ed);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = rstReq;
        bus.p0_req   = r0;
        bus.p0_we    = w0;
        bus.p0_addr  = a0;
        bus.p0_wdata = d0;
        bus.p1_req   = r1;
        bus.p1_lock  = l1;
        bus.p1_we    = w1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
        e.tag     = tag;
        e.ctrl    = {e0, e1, (e0 & w0) | (e1 & w1), r0 & ~e0};
        e.addr    = e1 ? a1 : a0;
        e.chkData = chk;
        e.rdata   = ed;
        if (!rstReq) begin
            expCnt = 16'd0;
            e.cnt  = 16'd0;
        end else begin
            e.cnt = expCnt;
            if (r0 && r1 && expCnt != 16'hFFFF)
                expCnt = expCnt + 16'd1;
        end
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput({e.tag, ".ctrl"}, {28'd0, bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.p0_stall}, {28'd0, e.ctrl});
            checkOutput({e.tag, ".addr"}, bus.mem_addr, e.addr);
            checkOutput({e.tag, ".cnt"}, {16'd0, conflictCnt}, {16'd0, e.cnt});
            if (e.chkData) begin
                checkOutput({e.tag, ".p0_rdata"}, bus.p0_rdata, e.rdata);
                checkOutput({e.tag, ".p1_rdata"}, bus.p1_rdata, e.rdata);
            end
        end
        if (rst && ((bus.p0_gnt && !bus.p0_req) || (bus.p1_gnt && !bus.p1_req) || (bus.p0_gnt && bus.p1_gnt))) begin
            testsFailed++;
            $display("[TB] FAIL grant_legal: p0_gnt=%0b p1_gnt=%0b, required one-hot grant to a requester (p0_req=%0b p1_req=%0b)",
                     bus.p0_gnt, bus.p1_gnt, bus.p0_req, bus.p1_req);
        end
    end

    initial begin
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_lock = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;

        // Reset held: request is stalled and no write reaches memory.
        rstReq = 1'b0;
        applyStimulus("rst_hold", 1,1,32'h10,32'hA5, 0,0,0,32'h0,32'h0, 0,0, 0,32'h0);
        rstReq = 1'b1;
        applyStimulus("p0_write", 1,1,32'h10,32'hA5, 0,0,0,32'h0,32'h0, 1,0, 0,32'h0);
        applyStimulus("p0_read",  1,0,32'h10,32'h0,  0,0,0,32'h0,32'h0, 1,0, 1,32'hA5);

        // Plain conflicts alternate starting with port 0.
        applyStimulus("rr1", 1,0,32'h20,0, 1,0,0,32'h30,0, 1,0, 0,0);
        applyStimulus("rr2", 1,0,32'h20,0, 1,0,0,32'h30,0, 0,1, 0,0);
        applyStimulus("rr3", 1,0,32'h20,0, 1,0,0,32'h30,0, 1,0, 0,0);
        applyStimulus("rr4", 1,0,32'h20,0, 1,0,0,32'h30,0, 0,1, 0,0);
        applyStimulus("idle_cnt4", 0,0,32'h0,0, 0,0,0,32'h0,0, 0,0, 0,0);

        // Full-length lock: 8 locked writes, then port 0 forced in, then round-robin from prio=1.
        applyStimulus("lock1", 0,0,32'h20,0, 1,1,1,32'h40,32'hC0DE0000, 0,1, 0,0);
        for (int k = 1; k < 8; k++)
            applyStimulus("lockN", 1,0,32'h40,0, 1,1,1,32'h40,32'hC0DE0000 | k, 0,1, 0,0);
        applyStimulus("lock_release", 1,0,32'h40,0, 1,1,1,32'h40,32'hDEAD0000, 1,0, 1,32'hC0DE0007);
        applyStimulus("post_rel_p1", 1,0,32'h20,0, 1,0,0,32'h30,0, 0,1, 0,0);
        applyStimulus("post_rel_p0", 1,0,32'h20,0, 1,0,0,32'h30,0, 1,0, 0,0);
        applyStimulus("idle2", 0,0,32'h0,0, 0,0,0,32'h0,0, 0,0, 0,0);

        // Lock dropped after 3 cycles: port 0 favoured in the unlocking cycle.
        applyStimulus("drop1", 0,0,32'h20,0, 1,1,0,32'h30,0, 0,1, 0,0);
        applyStimulus("drop2", 1,0,32'h20,0, 1,1,0,32'h30,0, 0,1, 0,0);
        applyStimulus("drop3", 1,0,32'h20,0, 1,1,0,32'h30,0, 0,1, 0,0);
        applyStimulus("drop_arb", 1,0,32'h20,0, 1,0,0,32'h30,0, 1,0, 0,0);
        applyStimulus("idle3", 0,0,32'h0,0, 0,0,0,32'h0,0, 0,0, 0,0);

        // Reset during the second locked cycle drops grants and the lock.
        applyStimulus("mid_lock1", 0,0,32'h20,0, 1,1,0,32'h30,0, 0,1, 0,0);
        rstReq = 1'b0;
        applyStimulus("mid_lock_rst", 1,0,32'h20,0, 1,1,0,32'h30,0, 0,0, 0,0);
        rstReq = 1'b1;
        applyStimulus("after_rst_p0", 1,0,32'h20,0, 1,0,0,32'h30,0, 1,0, 0,0);
        applyStimulus("after_rst_p1", 1,0,32'h20,0, 1,0,0,32'h30,0, 0,1, 0,0);

        // Saturation of the conflict counter from a fresh reset.
        rstReq = 1'b0;
        applyStimulus("sat_rst", 0,0,32'h0,0, 0,0,0,32'h0,0, 0,0, 0,0);
        rstReq = 1'b1;
        for (int i = 0; i < 70000; i++)
            applyStimulus("sat", 1,0,32'h50,0, 1,0,0,32'h60,0, (i % 2) == 0, (i % 2) == 1, 0, 0);
        applyStimulus("sat_idle", 0,0,32'h0,0, 0,0,0,32'h0,0, 0,0, 0,0);

        repeat (3) @(negedge clk);
        checkOutput("cnt_saturated", {16'd0, conflictCnt}, 32'h0000FFFF);
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
